// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, constants and helpers for the FPU normaliser
// Contents:
//   exp_all_ones(w) : all-ones biased exponent (Inf/NaN encoding) for a w-bit exponent
//   norm_flags_t    : per-beat result flags {zero, ovf, unf}
//   lzc_width(w)    : width of a leading-zero count over w bits (counts 0..w)
package fp_pkg;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } norm_flags_t;

    function automatic logic [31:0] exp_all_ones(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter, binary tree form
// Ports:
//   bits  in   W               value to scan, MSB first
//   count out  lzc_width(W)    number of leading zeros; W when bits == 0
module fp_lzc
    import fp_pkg::*;
#(
    parameter int W = 27
) (
    input  logic [W-1:0]            bits,
    output logic [lzc_width(W)-1:0] count
);

    localparam int CW = lzc_width(W);
    // Tree is CW levels deep over P > W leaves.
    localparam int P  = 1 << CW;

    // Pad below the LSB with ones: an all-zero input then naturally counts
    // to exactly W, so the tree never needs an "all invalid" special case.
    logic [P-1:0] pad;
    assign pad = (P'(bits) << (P - W)) | ((P'(1) << (P - W)) - P'(1));

    // Node (l, n) covers 2^l leaves; v = any one present, c = zeros above it.
    logic          v [CW+1][P];
    logic [CW-1:0] c [CW+1][P];

    always_comb begin
        for (int l = 0; l <= CW; l++) begin
            for (int n = 0; n < P; n++) begin
                v[l][n] = 1'b0;
                c[l][n] = '0;
            end
        end
        for (int n = 0; n < P; n++) begin
            v[0][n] = pad[n];
        end
        for (int l = 1; l <= CW; l++) begin
            for (int n = 0; n < (P >> l); n++) begin
                v[l][n] = v[l-1][2*n+1] | v[l-1][2*n];
                // Upper half empty: its full width of zeros precedes the lower count.
                if (v[l-1][2*n+1]) begin
                    c[l][n] = c[l-1][2*n+1];
                end else begin
                    c[l][n] = c[l-1][2*n] | CW'(1 << (l - 1));
                end
            end
        end
        count = c[CW][0];
    end

endmodule

// File: rtl/fp_normalize_pipe.sv
// rtl/fp_normalize_pipe.sv - 2-stage post-add mantissa normaliser with valid/ready
// Ports:
//   clk, rst_n           clock (rising), asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_mant [MAN_W:0]    raw sum; bit MAN_W carry-out, bit MAN_W-1 hidden position
//   in_exp  [EXP_W-1:0]  common biased exponent
//   out_valid/out_ready  output handshake
//   out_mant [MAN_W-1:0] normalised mantissa, bit 0 sticky
//   out_exp  [EXP_W-1:0] adjusted biased exponent
//   out_zero/ovf/unf     result flags, at most one set
module fp_normalize_pipe
    import fp_pkg::*;
#(
    parameter int MAN_W = 27,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W:0]   in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf
);

    localparam int LZC_W = lzc_width(MAN_W);
    localparam logic [EXP_W:0] EXP_ONES = (EXP_W+1)'(exp_all_ones(EXP_W));
    localparam logic [EXP_W:0] EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};

    logic             s1_v, s2_v, s1_ready, s2_ready;
    logic [MAN_W:0]   s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [LZC_W-1:0] s1_lzc;
    logic             s1_zero;
    logic [LZC_W-1:0] lzc;

    logic [MAN_W-1:0] s2_mant;
    logic [EXP_W-1:0] s2_exp;
    norm_flags_t      s2_flags;

    assign s2_ready = !s2_v || out_ready;
    assign s1_ready = !s1_v || s2_ready;
    assign in_ready = s1_ready;

    fp_lzc #(.W(MAN_W)) u_lzc (
        .bits  (in_mant[MAN_W-1:0]),
        .count (lzc)
    );

    // Stage-2 exponent arithmetic, one bit wider than the exponent so
    // nothing wraps.
    logic [EXP_W:0] e_in, lz_ext, e_inc, e_sub, e_dec;
    logic           lz_fits;

    assign e_in   = {1'b0, s1_exp};
    assign lz_ext = (EXP_W+1)'(s1_lzc);
    assign e_inc  = e_in + EXP_ONE;
    assign e_sub  = e_in - lz_ext;
    assign e_dec  = (e_in == '0) ? '0 : e_in - EXP_ONE;
    // lzc < exp exactly when the difference is positive (sign bit clear, non-zero).
    assign lz_fits = !e_sub[EXP_W] && (e_sub != '0);

    logic [MAN_W-1:0] n_mant;
    logic [EXP_W-1:0] n_exp;
    norm_flags_t      n_flags;

    always_comb begin
        n_mant  = '0;
        n_exp   = '0;
        n_flags = '0;
        if (s1_zero) begin
            n_flags.zero = 1'b1;
        end else if (e_in == EXP_ONES) begin
            // Inf/NaN operand: mantissa passes through unshifted.
            n_mant = s1_mant[MAN_W-1:0];
            n_exp  = s1_exp;
        end else if (s1_mant[MAN_W]) begin
            if (e_inc == EXP_ONES) begin
                n_flags.ovf = 1'b1;
                n_exp       = '1;
            end else begin
                n_mant = {s1_mant[MAN_W:2], s1_mant[1] | s1_mant[0]};
                n_exp  = e_inc[EXP_W-1:0];
            end
        end else if (lz_fits) begin
            n_mant = s1_mant[MAN_W-1:0] << s1_lzc;
            n_exp  = e_sub[EXP_W-1:0];
        end else begin
            // Denormal: shift only as far as exponent 1 allows, then clamp to 0.
            n_mant      = s1_mant[MAN_W-1:0] << e_dec;
            n_flags.unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v     <= 1'b0;
            s1_mant  <= '0;
            s1_exp   <= '0;
            s1_lzc   <= '0;
            s1_zero  <= 1'b0;
            s2_v     <= 1'b0;
            s2_mant  <= '0;
            s2_exp   <= '0;
            s2_flags <= '0;
        end else begin
            if (s1_ready) begin
                s1_v <= in_valid;
            end
            if (in_valid && s1_ready) begin
                s1_mant <= in_mant;
                s1_exp  <= in_exp;
                s1_lzc  <= lzc;
                s1_zero <= (in_mant == '0);
            end
            if (s2_ready) begin
                s2_v <= s1_v;
            end
            if (s1_v && s2_ready) begin
                s2_mant  <= n_mant;
                s2_exp   <= n_exp;
                s2_flags <= n_flags;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_mant  = s2_mant;
    assign out_exp   = s2_exp;
    assign out_zero  = s2_flags.zero;
    assign out_ovf   = s2_flags.ovf;
    assign out_unf   = s2_flags.unf;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// tb/tb_fp_normalize_pipe.sv - self-checking bench for fp_normalize_pipe
module tb_fp_normalize_pipe;

    localparam int MAN_W = 27;
    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [MAN_W:0]   in_mant = '0;
    logic [EXP_W-1:0] in_exp = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [MAN_W-1:0] out_mant;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero, out_ovf, out_unf;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    typedef struct packed {
        logic [MAN_W-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic             zero;
        logic             ovf;
        logic             unf;
    } res_t;

    res_t exp_q[$];

    always #5 clk = ~clk;

    fp_normalize_pipe #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the normalisation rules.
    function automatic res_t model(input logic [MAN_W:0] m, input logic [EXP_W-1:0] e);
        res_t   r;
        int     lz;
        int     ei;
        int     sh;
        longint mm;
        longint lo;
        r  = '0;
        ei = int'(e);
        mm = longint'(m);
        lo = mm & ((64'd1 << MAN_W) - 1);
        lz = 0;
        while (lz < MAN_W && m[MAN_W-1-lz] == 1'b0) lz++;
        if (mm == 0) begin
            r.zero = 1'b1;
        end else if (ei == 255) begin
            r.mant = MAN_W'(lo);
            r.exp  = e;
        end else if (m[MAN_W]) begin
            if (ei + 1 == 255) begin
                r.ovf = 1'b1;
                r.exp = 8'hFF;
            end else begin
                r.mant = MAN_W'((mm >> 1) | (mm & 1));
                r.exp  = EXP_W'(ei + 1);
            end
        end else if (lz < ei) begin
            r.mant = MAN_W'(lo << lz);
            r.exp  = EXP_W'(ei - lz);
        end else begin
            sh     = (ei == 0) ? 0 : ei - 1;
            r.mant = (sh >= MAN_W) ? '0 : MAN_W'(lo << sh);
            r.unf  = 1'b1;
        end
        return r;
    endfunction

    // Scoreboard: transfers are decided at the next rising edge, so sample
    // both handshakes on the falling edge.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got %h, expected none",
                         {out_mant, out_exp, out_zero, out_ovf, out_unf});
            end else begin
                e = exp_q.pop_front();
                check("out_beat", 64'({out_mant, out_exp, out_zero, out_ovf, out_unf}), 64'(e));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(in_mant, in_exp));
        end
    end

    // Enter and leave at posedge + 1.
    task automatic send(input logic [MAN_W:0] m, input logic [EXP_W-1:0] e);
        int t;
        t        = 0;
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    logic [MAN_W:0]   bm [4];
    logic [EXP_W-1:0] be [4];
    logic [MAN_W:0]   rm;
    logic [EXP_W-1:0] re;
    int k, guard, base;

    initial begin
        // Hand-computed pins on the model itself.
        check("model_carry",  64'(model(28'h8000001, 8'h80)), 64'({27'h4000001, 8'h81, 3'b000}));
        check("model_lzc26",  64'(model(28'h0000001, 8'h80)), 64'({27'h4000000, 8'h66, 3'b000}));
        check("model_unf",    64'(model(28'h0000100, 8'h05)), 64'({27'h0001000, 8'h00, 3'b001}));
        check("model_ovf",    64'(model(28'h8000000, 8'hFE)), 64'({27'h0000000, 8'hFF, 3'b010}));
        check("model_zero",   64'(model(28'h0000000, 8'h80)), 64'({27'h0000000, 8'h00, 3'b100}));

        // Reset state.
        idle(3);
        check("reset_in_ready",  64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_outputs",   64'({out_mant, out_exp, out_zero, out_ovf, out_unf}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: accepted at edge N, visible after edge N+1, transferred at N+2.
        out_ready = 1'b1;
        send(28'h8000001, 8'h80);
        check("lat_after_accept", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_next_edge", 64'(out_valid), 64'(1));
        check("lat_mant", 64'(out_mant), 64'(27'h4000001));
        check("lat_exp",  64'(out_exp),  64'(8'h81));

        // Directed beats back to back, checked by the scoreboard.
        send(28'h0000001, 8'h80);
        send(28'h0000100, 8'h05);
        send(28'h8000000, 8'hFE);
        send(28'h0000000, 8'h80);
        idle(4);

        // Stall: 4 beats offered while the output is blocked for 5 cycles.
        bm[0] = 28'h4000000; be[0] = 8'h10;
        bm[1] = 28'h8000003; be[1] = 8'h20;
        bm[2] = 28'h0000040; be[2] = 8'h03;
        bm[3] = 28'h0001234; be[3] = 8'h40;
        base = n_out;
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 4);
            in_mant  = bm[k % 4];
            in_exp   = be[k % 4];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        check("stall_accepted", 64'(k), 64'(2));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_no_output", 64'(n_out - base), 64'(0));
        out_ready = 1'b1;
        guard = 0;
        while (k < 4 && guard < 50) begin
            in_valid = 1'b1;
            in_mant  = bm[k];
            in_exp   = be[k];
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        idle(6);
        check("stall_all_out", 64'(n_out - base), 64'(4));

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || k == 1) begin
                case ($urandom_range(0, 5))
                    0:       rm = '0;
                    1:       rm = {1'b1, 27'($urandom)};
                    2:       rm = 28'($urandom) >> $urandom_range(0, 27);
                    3:       rm = 28'(1) << $urandom_range(0, 27);
                    default: rm = 28'($urandom);
                endcase
                case ($urandom_range(0, 6))
                    0:       re = 8'h00;
                    1:       re = 8'h01;
                    2:       re = 8'hFE;
                    3:       re = 8'hFF;
                    4:       re = 8'($urandom_range(1, 30));
                    default: re = 8'($urandom);
                endcase
                if (rm == '0 && re == 8'hFF) re = 8'h7F;
                in_valid = ($urandom_range(0, 3) != 0);
                in_mant  = rm;
                in_exp   = re;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k = (in_valid && in_ready) ? 1 : 0;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        check("random_drained", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send(28'h0000001, 8'h80);
        send(28'h8000001, 8'h80);
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        base = n_out;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        exp_q.delete();
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(6);
        check("post_reset_in_ready", 64'(in_ready), 64'(1));
        check("post_reset_no_stale", 64'(n_out - base), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
